addsub_arbiter: RTL and testbench

Shares one combinational WIDTH-bit adder-subtractor datapath (a, b, sub -> sum, cout) between two independent requesters. Each request is accepted with a valid/ready handshake, executed on the shared unit, and returned on that requester's own response channel. Grants are round-robin, so neither requester can starve the other. The block sits between the two operand sources and the single add/sub unit, which it instantiates internally.

---
 rtl/addsub_arbiter.sv | 155 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub unit between two requesters

// Shared combinational datapath: {cout, sum} = a + (b ^ {WIDTH{sub}}) + sub
module addsub_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             owner;
  logic             sel;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [WIDTH-1:0] u_sum;
  logic             u_cout;

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (u_sum),
    .cout (u_cout)
  );

  // Requester selection: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else begin
      sel = req1_valid;
    end
  end

  // Ready is offered only in IDLE and never while reset is held
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !sel;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign rsp_done   = owner ? rsp1_ready : rsp0_ready;

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on owner handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand latch and grant history, updated at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == IDLE && accept) begin
      a_q        <= sel ? req1_a : req0_a;
      b_q        <= sel ? req1_b : req0_b;
      sub_q      <= sel ? req1_sub : req0_sub;
      owner      <= sel;
      last_grant <= sel;
    end
  end

  // Response registers: capture in EXEC for the owner only, release on the owner's handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_sum   <= '0;
      rsp0_cout  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_sum   <= '0;
      rsp1_cout  <= 1'b0;
    end else if (state == EXEC) begin
      if (owner) begin
        rsp1_valid <= 1'b1;
        rsp1_sum   <= u_sum;
        rsp1_cout  <= u_cout;
      end else begin
        rsp0_valid <= 1'b1;
        rsp0_sum   <= u_sum;
        rsp0_cout  <= u_cout;
      end
    end else if (state == RESP && rsp_done) begin
      if (owner) begin
        rsp1_valid <= 1'b0;
      end else begin
        rsp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - scoreboard bench for addsub_arbiter
module tb_addsub_arbiter;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub, rsp0_valid, rsp0_ready, rsp0_cout;
  logic         req1_valid, req1_ready, req1_sub, rsp1_valid, rsp1_ready, rsp1_cout;
  logic [W-1:0] req0_a, req0_b, rsp0_sum, req1_a, req1_b, rsp1_sum;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   tb_last = 1'b1;
  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  bit   p0v, p0r, p0c, p1v, p1r, p1c;
  logic [W-1:0] p0s, p1s;
  bit   done_a, done_b;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_sum   (rsp0_sum),
    .rsp0_cout  (rsp0_cout),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_sum   (rsp1_sum),
    .rsp1_cout  (rsp1_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic; subtraction carry means a >= b
  function automatic exp_t model(input int a, input int b, input bit sub, input int c);
    exp_t e;
    int   r;
    if (sub) begin
      r      = a - b;
      e.cout = (a >= b);
    end else begin
      r      = a + b;
      e.cout = (r >= (1 << W));
    end
    r     = r & ((1 << W) - 1);
    e.sum = r[W-1:0];
    e.cyc = c;
    return e;
  endfunction

  // Monitor: records accepts into the scoreboard and checks every response
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      tb_last = 1'b1;
      p0v = 1'b0;
      p1v = 1'b0;
    end else begin
      if (req0_ready || req1_ready) chk("ready_exclusive", int'(req0_ready && req1_ready), 0);
      if (req0_valid && req0_ready) begin
        if (req1_valid) chk("tie_grant0", 0, tb_last ? 0 : 1);
        q0.push_back(model(int'(req0_a), int'(req0_b), req0_sub, cyc));
        glog.push_back(0);
        tb_last = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        if (req0_valid) chk("tie_grant1", 1, tb_last ? 0 : 1);
        q1.push_back(model(int'(req1_a), int'(req1_b), req1_sub, cyc));
        glog.push_back(1);
        tb_last = 1'b1;
      end
      if (rsp0_valid || rsp1_valid) chk("rsp_exclusive", int'(rsp0_valid && rsp1_valid), 0);

      if (rsp0_valid && !p0v && q0.size() > 0) chk("latency0", cyc, q0[0].cyc + 2);
      if (p0v && !p0r) begin
        chk("hold_valid0", int'(rsp0_valid), 1);
        chk("hold_sum0", int'(rsp0_sum), int'(p0s));
        chk("hold_cout0", int'(rsp0_cout), int'(p0c));
      end
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) begin
          chk("unexpected_rsp0", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("sum0", int'(rsp0_sum), int'(e.sum));
          chk("cout0", int'(rsp0_cout), int'(e.cout));
        end
      end

      if (rsp1_valid && !p1v && q1.size() > 0) chk("latency1", cyc, q1[0].cyc + 2);
      if (p1v && !p1r) begin
        chk("hold_valid1", int'(rsp1_valid), 1);
        chk("hold_sum1", int'(rsp1_sum), int'(p1s));
        chk("hold_cout1", int'(rsp1_cout), int'(p1c));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_rsp1", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("sum1", int'(rsp1_sum), int'(e.sum));
          chk("cout1", int'(rsp1_cout), int'(e.cout));
        end
      end

      p0v = rsp0_valid; p0r = rsp0_ready; p0s = rsp0_sum; p0c = rsp0_cout;
      p1v = rsp1_valid; p1r = rsp1_ready; p1s = rsp1_sum; p1c = rsp1_cout;
    end
  end

  // Present one request and hold it until the accept edge has passed
  task automatic issue(input int ch, input int a, input int b, input bit sub);
    int n = 0;
    if (ch == 0) begin
      req0_valid = 1'b1; req0_a = a[W-1:0]; req0_b = b[W-1:0]; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a[W-1:0]; req1_b = b[W-1:0]; req1_sub = sub;
    end
    forever begin
      @(negedge clk);
      if (ch == 0 ? req0_ready : req1_ready) break;
      n++;
      if (n > 200) begin
        chk("issue_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (ch == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rsp0_valid || rsp1_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", n, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp0();
    int n = 0;
    while (!rsp0_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rsp0_timeout", n, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0;   req1_b = '0;   req1_sub = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_valid0", int'(rsp0_valid), 0);
    chk("rst_valid1", int'(rsp1_valid), 0);
    chk("rst_sum0", int'(rsp0_sum), 0);
    chk("rst_sum1", int'(rsp1_sum), 0);
    chk("rst_cout1", int'(rsp1_cout), 0);

    // First op after reset: req0 alone, 1+2
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_ready0", int'(req0_ready), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rsp0();
    chk("first_sum0", int'(rsp0_sum), 3);
    chk("first_cout0", int'(rsp0_cout), 0);
    chk("first_valid1", int'(rsp1_valid), 0);
    drain();

    // Single requesters, including subtraction with borrow and overflow
    issue(1, 3, 1, 1'b1);
    drain();
    issue(0, 1, 2, 1'b1);
    drain();
    issue(0, 15, 1, 1'b0);
    drain();

    // Both requesters busy: strict alternation starting with req0
    do_reset();
    glog.delete();
    fork
      begin issue(0, 4, 5, 1'b0); issue(0, 9, 9, 1'b1); end
      begin issue(1, 7, 8, 1'b0); issue(1, 2, 6, 1'b1); end
    join
    drain();
    chk("order_len", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("order0", glog[0], 0);
      chk("order1", glog[1], 1);
      chk("order2", glog[2], 0);
      chk("order3", glog[3], 1);
    end

    // Backpressure on rsp0 while req1 waits
    rsp0_ready = 1'b0;
    issue(0, 5, 6, 1'b0);
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd3; req1_sub = 1'b1;
    wait_rsp0();
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready1", int'(req1_ready), 0);
      chk("bp_sum0", int'(rsp0_sum), 11);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("exit_ready1_early", int'(req1_ready), 0);
    @(negedge clk);
    chk("exit_ready1", int'(req1_ready), 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain();

    // Reset during EXEC of a req1 op discards it
    issue(1, 3, 1, 1'b1);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd6; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd7; req1_sub = 1'b1;
    #1;
    chk("mid_rst_valid1", int'(rsp1_valid), 0);
    chk("mid_rst_sum1", int'(rsp1_sum), 0);
    chk("mid_rst_ready0", int'(req0_ready), 0);
    chk("mid_rst_ready1", int'(req1_ready), 0);
    glog.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp1", int'(rsp1_valid), 0);
    end
    req0_valid = 1'b0;
    fork
      issue(0, 6, 6, 1'b0);
      issue(1, 5, 7, 1'b1);
    join
    drain();
    if (glog.size() > 0) chk("post_rst_first", glog[0], 0);
    else                 chk("post_rst_log", 0, 1);

    // req0 operands change while waiting behind a stalled req1 response
    rsp1_ready = 1'b0;
    issue(1, 2, 2, 1'b0);
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rsp1_ready = 1'b1;
    issue(0, 7, 5, 1'b1);
    wait_rsp0();
    chk("late_sum0", int'(rsp0_sum), 2);
    chk("late_cout0", int'(rsp0_cout), 1);
    drain();

    // Randomized traffic with random response backpressure
    done_a = 1'b0;
    done_b = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
        end
        done_a = 1'b1;
      end
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
        end
        done_b = 1'b1;
      end
      begin
        for (int n = 0; n < 5000 && !(done_a && done_b); n++) begin
          @(posedge clk);
          #1;
          rsp0_ready = 1'($urandom);
          rsp1_ready = 1'($urandom);
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
